// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the CPU sequencer and datapath debug decode:
// FSM state encodings, memory-wait defaults and counter width.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_e;

   localparam int unsigned MEM_TIMEOUT_DEF = 255;
   localparam int unsigned WAIT_CNT_W      = 8;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on data memory; expired flags the cycle in which
// the running count reaches TIMEOUT (valid range 1..255).
module mem_wait_timer
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = MEM_TIMEOUT_DEF
) (
   input  logic sysclk,
   input  logic cpu_resetn,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [WAIT_CNT_W-1:0] LAST = WAIT_CNT_W'(TIMEOUT - 1);

   logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

   // cnt_q holds the wait cycles already completed, so the current cycle is cnt_q+1
   assign expired = enable && (cnt_q >= LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + WAIT_CNT_W'(1);
      end
   end

   always_ff @(posedge sysclk or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer (Moore state, strobes decoded from state
// and decoder inputs). Define CPU_SEQ_PERF_EN to add cycle/instret counters.
module cpu_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
   input  logic       sysclk,
   input  logic       cpu_resetn,
   input  logic       run,
   input  logic       is_load,
   input  logic       is_store,
   input  logic       is_halt,
   input  logic       dec_reg_we,
   input  logic       mem_ready,
   output logic       ir_we,
   output logic       pc_we,
   output logic       rf_we,
   output logic       mem_re,
   output logic       mem_we,
   output logic [2:0] state,
   output logic       halted,
   output logic       mem_err
`ifdef CPU_SEQ_PERF_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instret
`endif
);

   state_e state_q, state_d;
   logic   mem_err_q, mem_err_d;
   logic   wait_expired;
   logic   timeout_hit;

   mem_wait_timer #(
      .TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .sysclk     (sysclk),
      .cpu_resetn (cpu_resetn),
      .clear      (state_q != S_MEM),
      .enable     (state_q == S_MEM),
      .expired    (wait_expired)
   );

   always_comb begin
      state_d     = state_q;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      rf_we       = 1'b0;
      mem_re      = 1'b0;
      mem_we      = 1'b0;
      timeout_hit = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            ir_we   = 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            state_d = is_halt ? S_HALT : S_EXEC;
         end
         S_EXEC: begin
            if (is_load || is_store) begin
               state_d = S_MEM;
            end else if (dec_reg_we) begin
               state_d = S_WB;
            end else begin
               pc_we   = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_MEM: begin
            // A load wins if the decoder flags both
            mem_re = is_load;
            mem_we = is_store && !is_load;
            if (mem_ready) begin
               if (is_load) begin
                  state_d = S_WB;
               end else begin
                  pc_we   = 1'b1;
                  state_d = S_FETCH;
               end
            end else if (wait_expired) begin
               timeout_hit = 1'b1;
               state_d     = S_HALT;
            end
         end
         S_WB: begin
            rf_we   = dec_reg_we;
            pc_we   = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_HALT;
         end
      endcase
   end

   assign mem_err_d = mem_err_q || timeout_hit;

   always_ff @(posedge sysclk or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         state_q   <= S_IDLE;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mem_err_q <= mem_err_d;
      end
   end

   assign state   = state_q;
   assign halted  = (state_q == S_HALT);
   assign mem_err = mem_err_q;

`ifdef CPU_SEQ_PERF_EN
   logic [31:0] cycle_cnt_q, cycle_cnt_d;
   logic [31:0] instret_q, instret_d;

   assign cycle_cnt_d = ((state_q != S_IDLE) && (state_q != S_HALT)) ? cycle_cnt_q + 32'd1
                                                                     : cycle_cnt_q;
   assign instret_d   = pc_we ? instret_q + 32'd1 : instret_q;

   always_ff @(posedge sysclk or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         cycle_cnt_q <= '0;
         instret_q   <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
         instret_q   <= instret_d;
      end
   end

   assign cycle_cnt = cycle_cnt_q;
   assign instret   = instret_q;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer built with MEM_TIMEOUT=4.
module tb_cpu_sequencer;

   typedef struct packed {
      logic [5:0] in;   // {run, is_load, is_store, is_halt, dec_reg_we, mem_ready}
      logic [9:0] exp;  // {ir_we, pc_we, rf_we, mem_re, mem_we, state[2:0], halted, mem_err}
   } row_t;

   logic       sysclk = 1'b0;
   logic       cpu_resetn = 1'b0;
   logic       run = 1'b0, is_load = 1'b0, is_store = 1'b0, is_halt = 1'b0;
   logic       dec_reg_we = 1'b0, mem_ready = 1'b0;
   logic       ir_we, pc_we, rf_we, mem_re, mem_we, halted, mem_err;
   logic [2:0] state;

   int         checks = 0;
   int         errors = 0;
   logic [9:0] exp_q[$];

   always #5 sysclk = ~sysclk;

   cpu_sequencer #(.MEM_TIMEOUT(4)) dut (
      .sysclk     (sysclk),
      .cpu_resetn (cpu_resetn),
      .run        (run),
      .is_load    (is_load),
      .is_store   (is_store),
      .is_halt    (is_halt),
      .dec_reg_we (dec_reg_we),
      .mem_ready  (mem_ready),
      .ir_we      (ir_we),
      .pc_we      (pc_we),
      .rf_we      (rf_we),
      .mem_re     (mem_re),
      .mem_we     (mem_we),
      .state      (state),
      .halted     (halted),
      .mem_err    (mem_err)
   );

   function automatic logic [9:0] ev(input logic ir, pc, rf, re, we,
                                     input logic [2:0] st, input logic h, e);
      return {ir, pc, rf, re, we, st, h, e};
   endfunction

   function automatic logic [9:0] obs();
      return {ir_we, pc_we, rf_we, mem_re, mem_we, state, halted, mem_err};
   endfunction

   task automatic apply_reset();
      {run, is_load, is_store, is_halt, dec_reg_we, mem_ready} = 6'b0;
      cpu_resetn = 1'b0;
      @(posedge sysclk); #1;
      cpu_resetn = 1'b1;
   endtask

   task automatic test_reset();
      row_t t[$];
      logic [9:0] e;
      cpu_resetn = 1'b0;
      {run, is_load, is_store, is_halt, dec_reg_we, mem_ready} = 6'b111111;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(ev(0,0,0,0,0,3'd0,0,0));
         @(negedge sysclk);
         e = exp_q.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL reset_hold[%0d] got=%b exp=%b", i, obs(), e);
         end
      end
      @(posedge sysclk); #1;
      cpu_resetn = 1'b1;
      t.push_back('{6'b000000, ev(0,0,0,0,0,3'd0,0,0)});
      t.push_back('{6'b000000, ev(0,0,0,0,0,3'd0,0,0)});
      t.push_back('{6'b100000, ev(0,0,0,0,0,3'd0,0,0)});
      t.push_back('{6'b000000, ev(1,0,0,0,0,3'd1,0,0)});
      foreach (t[i]) begin
         {run, is_load, is_store, is_halt, dec_reg_we, mem_ready} = t[i].in;
         exp_q.push_back(t[i].exp);
         @(negedge sysclk);
         e = exp_q.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL reset_start[%0d] got=%b exp=%b", i, obs(), e);
         end
         @(posedge sysclk); #1;
      end
   endtask

   task automatic test_alu();
      row_t t[$];
      logic [9:0] e;
      apply_reset();
      t.push_back('{6'b100010, ev(0,0,0,0,0,3'd0,0,0)});
      t.push_back('{6'b000010, ev(1,0,0,0,0,3'd1,0,0)});
      t.push_back('{6'b000010, ev(0,0,0,0,0,3'd2,0,0)});
      t.push_back('{6'b000010, ev(0,0,0,0,0,3'd3,0,0)});
      t.push_back('{6'b000010, ev(0,1,1,0,0,3'd5,0,0)});
      t.push_back('{6'b000010, ev(1,0,0,0,0,3'd1,0,0)});
      foreach (t[i]) begin
         {run, is_load, is_store, is_halt, dec_reg_we, mem_ready} = t[i].in;
         exp_q.push_back(t[i].exp);
         @(negedge sysclk);
         e = exp_q.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL alu_wb[%0d] got=%b exp=%b", i, obs(), e);
         end
         @(posedge sysclk); #1;
      end
   endtask

   task automatic test_nowb();
      row_t t[$];
      logic [9:0] e;
      apply_reset();
      t.push_back('{6'b100000, ev(0,0,0,0,0,3'd0,0,0)});
      t.push_back('{6'b000000, ev(1,0,0,0,0,3'd1,0,0)});
      t.push_back('{6'b000000, ev(0,0,0,0,0,3'd2,0,0)});
      t.push_back('{6'b000000, ev(0,1,0,0,0,3'd3,0,0)});
      t.push_back('{6'b000000, ev(1,0,0,0,0,3'd1,0,0)});
      foreach (t[i]) begin
         {run, is_load, is_store, is_halt, dec_reg_we, mem_ready} = t[i].in;
         exp_q.push_back(t[i].exp);
         @(negedge sysclk);
         e = exp_q.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL nowb[%0d] got=%b exp=%b", i, obs(), e);
         end
         @(posedge sysclk); #1;
      end
   endtask

   // mem_ready arrives in the same cycle the timeout count is reached
   task automatic test_load();
      row_t t[$];
      logic [9:0] e;
      apply_reset();
      t.push_back('{6'b110010, ev(0,0,0,0,0,3'd0,0,0)});
      t.push_back('{6'b010010, ev(1,0,0,0,0,3'd1,0,0)});
      t.push_back('{6'b010010, ev(0,0,0,0,0,3'd2,0,0)});
      t.push_back('{6'b010010, ev(0,0,0,0,0,3'd3,0,0)});
      t.push_back('{6'b010010, ev(0,0,0,1,0,3'd4,0,0)});
      t.push_back('{6'b010010, ev(0,0,0,1,0,3'd4,0,0)});
      t.push_back('{6'b010010, ev(0,0,0,1,0,3'd4,0,0)});
      t.push_back('{6'b010011, ev(0,0,0,1,0,3'd4,0,0)});
      t.push_back('{6'b010010, ev(0,1,1,0,0,3'd5,0,0)});
      t.push_back('{6'b010010, ev(1,0,0,0,0,3'd1,0,0)});
      foreach (t[i]) begin
         {run, is_load, is_store, is_halt, dec_reg_we, mem_ready} = t[i].in;
         exp_q.push_back(t[i].exp);
         @(negedge sysclk);
         e = exp_q.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL load_wait[%0d] got=%b exp=%b", i, obs(), e);
         end
         @(posedge sysclk); #1;
      end
   endtask

   task automatic test_store_priority();
      row_t t[$];
      logic [9:0] e;
      apply_reset();
      t.push_back('{6'b101001, ev(0,0,0,0,0,3'd0,0,0)});
      t.push_back('{6'b001001, ev(1,0,0,0,0,3'd1,0,0)});
      t.push_back('{6'b001001, ev(0,0,0,0,0,3'd2,0,0)});
      t.push_back('{6'b001001, ev(0,0,0,0,0,3'd3,0,0)});
      t.push_back('{6'b001001, ev(0,1,0,0,1,3'd4,0,0)});
      t.push_back('{6'b011011, ev(1,0,0,0,0,3'd1,0,0)});
      t.push_back('{6'b011011, ev(0,0,0,0,0,3'd2,0,0)});
      t.push_back('{6'b011011, ev(0,0,0,0,0,3'd3,0,0)});
      t.push_back('{6'b011011, ev(0,0,0,1,0,3'd4,0,0)});
      t.push_back('{6'b011011, ev(0,1,1,0,0,3'd5,0,0)});
      t.push_back('{6'b011011, ev(1,0,0,0,0,3'd1,0,0)});
      foreach (t[i]) begin
         {run, is_load, is_store, is_halt, dec_reg_we, mem_ready} = t[i].in;
         exp_q.push_back(t[i].exp);
         @(negedge sysclk);
         e = exp_q.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL store_prio[%0d] got=%b exp=%b", i, obs(), e);
         end
         @(posedge sysclk); #1;
      end
   endtask

   task automatic test_timeout();
      row_t t[$];
      logic [9:0] e;
      apply_reset();
      t.push_back('{6'b110010, ev(0,0,0,0,0,3'd0,0,0)});
      t.push_back('{6'b010010, ev(1,0,0,0,0,3'd1,0,0)});
      t.push_back('{6'b010010, ev(0,0,0,0,0,3'd2,0,0)});
      t.push_back('{6'b010010, ev(0,0,0,0,0,3'd3,0,0)});
      t.push_back('{6'b010010, ev(0,0,0,1,0,3'd4,0,0)});
      t.push_back('{6'b010010, ev(0,0,0,1,0,3'd4,0,0)});
      t.push_back('{6'b010010, ev(0,0,0,1,0,3'd4,0,0)});
      t.push_back('{6'b010010, ev(0,0,0,1,0,3'd4,0,0)});
      t.push_back('{6'b110011, ev(0,0,0,0,0,3'd6,1,1)});
      t.push_back('{6'b010011, ev(0,0,0,0,0,3'd6,1,1)});
      t.push_back('{6'b110011, ev(0,0,0,0,0,3'd6,1,1)});
      foreach (t[i]) begin
         {run, is_load, is_store, is_halt, dec_reg_we, mem_ready} = t[i].in;
         exp_q.push_back(t[i].exp);
         @(negedge sysclk);
         e = exp_q.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL timeout[%0d] got=%b exp=%b", i, obs(), e);
         end
         @(posedge sysclk); #1;
      end
      #2 cpu_resetn = 1'b0;
      exp_q.push_back(ev(0,0,0,0,0,3'd0,0,0));
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL timeout_async_reset got=%b exp=%b", obs(), e);
      end
   endtask

   task automatic test_halt();
      row_t t[$];
      logic [9:0] e;
      apply_reset();
      t.push_back('{6'b100100, ev(0,0,0,0,0,3'd0,0,0)});
      t.push_back('{6'b000100, ev(1,0,0,0,0,3'd1,0,0)});
      t.push_back('{6'b000100, ev(0,0,0,0,0,3'd2,0,0)});
      t.push_back('{6'b100000, ev(0,0,0,0,0,3'd6,1,0)});
      t.push_back('{6'b000000, ev(0,0,0,0,0,3'd6,1,0)});
      t.push_back('{6'b100000, ev(0,0,0,0,0,3'd6,1,0)});
      foreach (t[i]) begin
         {run, is_load, is_store, is_halt, dec_reg_we, mem_ready} = t[i].in;
         exp_q.push_back(t[i].exp);
         @(negedge sysclk);
         e = exp_q.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL halt[%0d] got=%b exp=%b", i, obs(), e);
         end
         @(posedge sysclk); #1;
      end
      #2 cpu_resetn = 1'b0;
      exp_q.push_back(ev(0,0,0,0,0,3'd0,0,0));
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL halt_async_reset got=%b exp=%b", obs(), e);
      end
   endtask

   task automatic test_reset_mid_mem();
      row_t t[$];
      logic [9:0] e;
      apply_reset();
      t.push_back('{6'b101000, ev(0,0,0,0,0,3'd0,0,0)});
      t.push_back('{6'b001000, ev(1,0,0,0,0,3'd1,0,0)});
      t.push_back('{6'b001000, ev(0,0,0,0,0,3'd2,0,0)});
      t.push_back('{6'b001000, ev(0,0,0,0,0,3'd3,0,0)});
      t.push_back('{6'b001000, ev(0,0,0,0,1,3'd4,0,0)});
      foreach (t[i]) begin
         {run, is_load, is_store, is_halt, dec_reg_we, mem_ready} = t[i].in;
         exp_q.push_back(t[i].exp);
         @(negedge sysclk);
         e = exp_q.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL mid_mem[%0d] got=%b exp=%b", i, obs(), e);
         end
         @(posedge sysclk); #1;
      end
      cpu_resetn = 1'b0;
      exp_q.push_back(ev(0,0,0,0,0,3'd0,0,0));
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL mid_mem_async_reset got=%b exp=%b", obs(), e);
      end
   endtask

   // Second load would time out if the wait count were not cleared on MEM entry
   task automatic test_back_to_back();
      row_t t[$];
      logic [9:0] e;
      apply_reset();
      t.push_back('{6'b110010, ev(0,0,0,0,0,3'd0,0,0)});
      for (int k = 0; k < 2; k++) begin
         t.push_back('{6'b010010, ev(1,0,0,0,0,3'd1,0,0)});
         t.push_back('{6'b010010, ev(0,0,0,0,0,3'd2,0,0)});
         t.push_back('{6'b010010, ev(0,0,0,0,0,3'd3,0,0)});
         t.push_back('{6'b010010, ev(0,0,0,1,0,3'd4,0,0)});
         t.push_back('{6'b010010, ev(0,0,0,1,0,3'd4,0,0)});
         t.push_back('{6'b010010, ev(0,0,0,1,0,3'd4,0,0)});
         t.push_back('{6'b010011, ev(0,0,0,1,0,3'd4,0,0)});
         t.push_back('{6'b010010, ev(0,1,1,0,0,3'd5,0,0)});
      end
      t.push_back('{6'b010010, ev(1,0,0,0,0,3'd1,0,0)});
      foreach (t[i]) begin
         {run, is_load, is_store, is_halt, dec_reg_we, mem_ready} = t[i].in;
         exp_q.push_back(t[i].exp);
         @(negedge sysclk);
         e = exp_q.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL back_to_back[%0d] got=%b exp=%b", i, obs(), e);
         end
         @(posedge sysclk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_nowb();
      test_load();
      test_store_priority();
      test_timeout();
      test_halt();
      test_reset_mid_mem();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
